cohort_mshr_arbiter: RTL

Parametrised successor to the per-tile MSHR/NoC request funnel in the cohort engine. It arbitrates memory requests from SOURCE_NUM consumer channels onto one NoC2 request port and allocates MSHR ids dynamically from a configurable pool instead of fixed per-source ranges. It also routes NoC3 responses back to the owning channel by MSHR id and frees the id. It sits between the per-consumer fifo controllers and the translator unit.

---
 rtl/cohort_mshr_arbiter_if.sv | 41 ++++
 rtl/cohort_mshr_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/cohort_mshr_arbiter_if.sv
// cohort_mshr_arbiter_if: channel request, NoC2 sink, NoC3 response and status bundle
interface cohort_mshr_arbiter_if #(
  parameter int SOURCE_NUM  = 11,
  parameter int PER_SRC_MAX = 4,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64
);
  localparam int CW = $clog2(PER_SRC_MAX + 1);
  logic [SOURCE_NUM-1:0]        src_en;
  logic [SOURCE_NUM-1:0]        src_req_valid;
  logic [SOURCE_NUM-1:0]        src_req_ready;
  logic [SOURCE_NUM*3-1:0]      src_req_type;
  logic [SOURCE_NUM*ADDR_W-1:0] src_req_addr;
  logic [SOURCE_NUM*DATA_W-1:0] src_req_data;
  logic                         sink_valid;
  logic                         sink_ready;
  logic [2:0]                   sink_type;
  logic [ADDR_W-1:0]            sink_addr;
  logic [DATA_W-1:0]            sink_data;
  logic [7:0]                   sink_mshrid;
  logic                         resp_valid;
  logic [7:0]                   resp_mshrid;
  logic [DATA_W-1:0]            resp_data;
  logic [SOURCE_NUM-1:0]        src_resp_valid;
  logic [DATA_W-1:0]            src_resp_data;
  logic [SOURCE_NUM*CW-1:0]     outstanding;
  logic                         err_bad_resp;
  logic [SOURCE_NUM*32-1:0]     perf_stall;
  modport slave (
    input  src_en, src_req_valid, src_req_type, src_req_addr, src_req_data,
    input  sink_ready, resp_valid, resp_mshrid, resp_data,
    output src_req_ready, sink_valid, sink_type, sink_addr, sink_data, sink_mshrid,
    output src_resp_valid, src_resp_data, outstanding, err_bad_resp, perf_stall
  );
  modport master (
    output src_en, src_req_valid, src_req_type, src_req_addr, src_req_data,
    output sink_ready, resp_valid, resp_mshrid, resp_data,
    input  src_req_ready, sink_valid, sink_type, sink_addr, sink_data, sink_mshrid,
    input  src_resp_valid, src_resp_data, outstanding, err_bad_resp, perf_stall
  );
endinterface

// File: rtl/cohort_mshr_arbiter.sv
// cohort_mshr_arbiter: round-robin NoC2 request funnel with pooled MSHR ids and NoC3 response routing
// Optional per-channel stall counters are built when COHORT_MSHR_PERF_EN is defined.
module cohort_mshr_arbiter #(
  parameter int SOURCE_NUM  = 11,
  parameter int MSHR_BASE   = 128,
  parameter int MSHR_NUM    = 16,
  parameter int PER_SRC_MAX = 4,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64
) (
  input logic clk,
  input logic rst,
  cohort_mshr_arbiter_if.slave bus
);
  localparam int SW = SOURCE_NUM > 1 ? $clog2(SOURCE_NUM) : 1;
  localparam int MW = $clog2(MSHR_NUM);
  localparam int CW = $clog2(PER_SRC_MAX + 1);
  logic [MSHR_NUM-1:0]   free_q;
  logic [SW-1:0]         owner_q [MSHR_NUM];
  logic [CW-1:0]         cnt_q [SOURCE_NUM];
  logic [SW-1:0]         rr_q;
  logic [SOURCE_NUM-1:0] elig, gnt, rel;
  logic [SW-1:0]         gnt_idx;
  logic                  gnt_any, fire, resp_in, resp_hit;
  logic [MW-1:0]         alloc_idx, resp_idx;
  logic [MSHR_NUM-1:0]   alloc_mask, rel_mask;
  int                    j;
  assign fire = !bus.sink_valid || bus.sink_ready;
  always_comb begin
    elig = '0;
    for (int i = 0; i < SOURCE_NUM; i++)
      elig[i] = bus.src_req_valid[i] && bus.src_en[i] && cnt_q[i] < CW'(PER_SRC_MAX) && |free_q && fire;
  end
  // descending scan so the lowest rotated offset from the pointer wins
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j = 0;
    for (int k = SOURCE_NUM - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      j = j >= SOURCE_NUM ? j - SOURCE_NUM : j;
      if (elig[SW'(j)]) begin
        gnt_idx = SW'(j);
        gnt_any = 1'b1;
      end
    end
    gnt = gnt_any ? SOURCE_NUM'(1) << gnt_idx : '0;
  end
  always_comb begin
    alloc_idx = '0;
    for (int m = MSHR_NUM - 1; m >= 0; m--)
      if (free_q[m]) alloc_idx = MW'(m);
  end
  assign resp_in    = int'(bus.resp_mshrid) >= MSHR_BASE && int'(bus.resp_mshrid) < MSHR_BASE + MSHR_NUM;
  assign resp_idx   = MW'(int'(bus.resp_mshrid) - MSHR_BASE);
  assign resp_hit   = bus.resp_valid && resp_in && !free_q[resp_idx];
  assign rel        = resp_hit ? SOURCE_NUM'(1) << owner_q[resp_idx] : '0;
  assign alloc_mask = gnt_any ? MSHR_NUM'(1) << alloc_idx : '0;
  assign rel_mask   = resp_hit ? MSHR_NUM'(1) << resp_idx : '0;
  assign bus.src_req_ready = gnt;
  always_comb begin
    bus.outstanding = '0;
    for (int i = 0; i < SOURCE_NUM; i++) bus.outstanding[i*CW +: CW] = cnt_q[i];
  end
  // an id freed by this cycle's response only rejoins the pool after the edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      free_q             <= '1;
      rr_q               <= '0;
      bus.sink_valid     <= 1'b0;
      bus.sink_type      <= '0;
      bus.sink_addr      <= '0;
      bus.sink_data      <= '0;
      bus.sink_mshrid    <= '0;
      bus.src_resp_valid <= '0;
      bus.src_resp_data  <= '0;
      bus.err_bad_resp   <= 1'b0;
      for (int m = 0; m < MSHR_NUM; m++) owner_q[m] <= '0;
      for (int i = 0; i < SOURCE_NUM; i++) cnt_q[i] <= '0;
    end else begin
      if (gnt_any) begin
        bus.sink_valid     <= 1'b1;
        bus.sink_type      <= bus.src_req_type[gnt_idx*3 +: 3];
        bus.sink_addr      <= bus.src_req_addr[gnt_idx*ADDR_W +: ADDR_W];
        bus.sink_data      <= bus.src_req_data[gnt_idx*DATA_W +: DATA_W];
        bus.sink_mshrid    <= 8'(MSHR_BASE + int'(alloc_idx));
        owner_q[alloc_idx] <= gnt_idx;
        rr_q               <= int'(gnt_idx) == SOURCE_NUM - 1 ? '0 : gnt_idx + SW'(1);
      end else if (bus.sink_ready) bus.sink_valid <= 1'b0;
      free_q             <= (free_q & ~alloc_mask) | rel_mask;
      bus.src_resp_valid <= rel;
      if (resp_hit) bus.src_resp_data <= bus.resp_data;
      bus.err_bad_resp   <= bus.err_bad_resp || (bus.resp_valid && !resp_hit);
      for (int i = 0; i < SOURCE_NUM; i++) cnt_q[i] <= cnt_q[i] + CW'(gnt[i]) - CW'(rel[i]);
    end
`ifdef COHORT_MSHR_PERF_EN
  logic [31:0] perf_q [SOURCE_NUM];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < SOURCE_NUM; i++) perf_q[i] <= '0;
    else
      for (int i = 0; i < SOURCE_NUM; i++)
        if (bus.src_req_valid[i] && bus.src_en[i] && !gnt[i] && perf_q[i] != '1) perf_q[i] <= perf_q[i] + 32'd1;
  always_comb begin
    bus.perf_stall = '0;
    for (int i = 0; i < SOURCE_NUM; i++) bus.perf_stall[i*32 +: 32] = perf_q[i];
  end
`else
  assign bus.perf_stall = '0;
`endif
endmodule
